// File: rtl/up_bus_responder_pkg.sv
// Shared types and defaults for the uP byte-transfer responder.
// Holds the FSM state encoding and the lane-insert helper used by the word assembler.
package up_bus_responder_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_ACK   = 3'd2,
    S_REL   = 3'd3
  } responder_state_t;

  localparam int RESP_TIMEOUT_DEFAULT     = 50000;
  localparam int RESP_NOS_BYTES_DEFAULT   = 4;
  localparam int RESP_SYNC_STAGES_DEFAULT = 2;

  function automatic logic [31:0] lane_insert(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [7:0]  data);
    logic [31:0] w_word;
    w_word = word;
    w_word[{lane, 3'b000} +: 8] = data;
    return w_word;
  endfunction

endpackage

// File: rtl/up_bus_responder_if.sv
// uP pin bundle: request/start-of-word/data from the uP, acknowledge and busy line back.
// The master modport is the uP side, the slave modport is the FPGA responder.
interface up_bus_responder_if;
  logic       up_handshake_1;
  logic       up_handshake_2;
  logic [7:0] up_data;
  logic       bus_handshake_1;
  logic       bus_handshake_2;
  logic       bus_hs2_oe;

  modport master (
    output up_handshake_1, up_handshake_2, up_data,
    input  bus_handshake_1, bus_handshake_2, bus_hs2_oe
  );

  modport slave (
    input  up_handshake_1, up_handshake_2, up_data,
    output bus_handshake_1, bus_handshake_2, bus_hs2_oe
  );
endinterface

// File: rtl/up_bus_responder_sync_2ff.sv
// Multi-stage flip-flop synchroniser for asynchronous inputs.
// Width and depth are parameters; all stages reset asynchronously to 0.
module sync_2ff #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  // Shift the asynchronous input through the stage chain.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= {WIDTH{1'b0}};
      end
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/up_bus_responder.sv
// FPGA end of the uP four-phase byte handshake; assembles NOS_BYTES bytes (LS first)
// into rx_word, holds off new requests while a word is unconsumed, and flags stuck acks.
module up_bus_responder
  import up_bus_responder_pkg::*;
#(
  parameter int NOS_BYTES      = RESP_NOS_BYTES_DEFAULT,
  parameter int TIMEOUT_CYCLES = RESP_TIMEOUT_DEFAULT,
  parameter int SYNC_STAGES    = RESP_SYNC_STAGES_DEFAULT
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  up_bus_responder_if.slave    io_up,
  output logic [31:0]          o_rx_word,
  output logic                 o_rx_word_valid,
  input  logic                 i_rx_word_ack,
  output logic                 o_timeout_err
);

  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  CNT_FULL  = 3'(NOS_BYTES);

  logic [1:0]       w_sync;
  logic             w_req_s;
  logic             w_sof_s;
  responder_state_t r_state;
  responder_state_t w_next_state;
  logic             w_tmo_hit;
  logic [2:0]       r_cnt;
  logic [2:0]       w_cnt_base;
  logic [2:0]       w_cnt_next;
  logic [31:0]      r_asm;
  logic [31:0]      w_asm_base;
  logic [31:0]      w_asm_next;
  logic [31:0]      r_rx_word;
  logic [31:0]      w_rx_word_next;
  logic             w_word_done;
  logic             r_valid;
  logic             w_valid_next;
  logic             r_ack;
  logic             r_oe;
  logic             r_err;
  logic [15:0]      r_tmo;

  sync_2ff #(
    .WIDTH (2),
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     ({io_up.up_handshake_2, io_up.up_handshake_1}),
    .o_q     (w_sync)
  );

  assign w_req_s = w_sync[0];
  assign w_sof_s = w_sync[1];
  assign w_tmo_hit = (r_state == S_ACK) && (r_tmo == TMO_LAST);

  // Next-state logic for the handshake FSM.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req_s && !r_valid) begin
          w_next_state = S_LATCH;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_LATCH: w_next_state = S_ACK;
      S_ACK: begin
        if (w_tmo_hit) begin
          w_next_state = S_IDLE;
        end else if (!w_req_s) begin
          w_next_state = S_REL;
        end else begin
          w_next_state = S_ACK;
        end
      end
      S_REL:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Byte assembly, word hand-off and consumer valid tracking.
  always_comb begin
    w_cnt_base     = r_cnt;
    w_asm_base     = r_asm;
    w_cnt_next     = r_cnt;
    w_asm_next     = r_asm;
    w_rx_word_next = r_rx_word;
    w_word_done    = 1'b0;
    case (r_state)
      S_LATCH: begin
        // A start-of-word marker drops whatever partial word was in flight.
        if (w_sof_s) begin
          w_cnt_base = 3'd0;
          w_asm_base = 32'h0000_0000;
        end else begin
          w_cnt_base = r_cnt;
          w_asm_base = r_asm;
        end
        w_asm_next = lane_insert(w_asm_base, w_cnt_base[1:0], io_up.up_data);
        w_cnt_next = w_cnt_base + 3'd1;
      end
      S_ACK: begin
        if (w_tmo_hit) begin
          w_cnt_next = 3'd0;
          w_asm_next = 32'h0000_0000;
        end else begin
          w_cnt_next = r_cnt;
        end
      end
      S_REL: begin
        if (r_cnt == CNT_FULL) begin
          w_word_done    = 1'b1;
          w_rx_word_next = r_asm;
          w_cnt_next     = 3'd0;
          w_asm_next     = 32'h0000_0000;
        end else begin
          w_word_done = 1'b0;
        end
      end
      default: w_word_done = 1'b0;
    endcase

    if (w_word_done) begin
      w_valid_next = 1'b1;
    end else if (i_rx_word_ack) begin
      w_valid_next = 1'b0;
    end else begin
      w_valid_next = r_valid;
    end
  end

  // State, datapath and registered pin outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 3'd0;
      r_asm     <= 32'h0000_0000;
      r_rx_word <= 32'h0000_0000;
      r_valid   <= 1'b0;
      r_ack     <= 1'b0;
      r_oe      <= 1'b0;
      r_err     <= 1'b0;
      r_tmo     <= 16'd0;
    end else begin
      r_state   <= w_next_state;
      r_cnt     <= w_cnt_next;
      r_asm     <= w_asm_next;
      r_rx_word <= w_rx_word_next;
      r_valid   <= w_valid_next;
      r_ack     <= (w_next_state == S_ACK);
      r_oe      <= w_valid_next | (w_next_state != S_IDLE);
      r_err     <= r_err | w_tmo_hit;
      if (w_next_state != r_state) begin
        r_tmo <= 16'd0;
      end else if (r_state == S_ACK) begin
        r_tmo <= r_tmo + 16'd1;
      end else begin
        r_tmo <= r_tmo;
      end
    end
  end

  assign io_up.bus_handshake_1 = r_ack;
  assign io_up.bus_handshake_2 = 1'b0;
  assign io_up.bus_hs2_oe      = r_oe;
  assign o_rx_word             = r_rx_word;
  assign o_rx_word_valid       = r_valid;
  assign o_timeout_err         = r_err;

endmodule
